// File: rtl/sys_rmw_engine_pkg.sv
// Shared types and constants for the read-modify-write stress engine.
package sys_rmw_engine_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_SEED_W = 16;
  localparam int NUM_LFSR   = 4;

  // x^16+x^14+x^13+x^11+1 -> feedback from bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;

  typedef enum logic [2:0] {
    ST_GEN,
    ST_RD,
    ST_RD_GAP,
    ST_WR,
    ST_WR_GAP
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sys_rmw_engine_lfsr16.sv
// Seedable 16-bit Fibonacci LFSR; reset loads the seed, an all-zero seed is
// swapped for a fixed non-zero value so the register can never lock up.
module lfsr16
  import sys_rmw_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= (seed_i == 16'h0) ? LFSR_ZERO_SUB : seed_i;
    else if (en_i) q_q <= lfsr_next(q_q);
  end

  assign q_o = q_q;

endmodule

// File: rtl/sys_rmw_engine.sv
// Bus-master stress engine: pseudo-random address, read it, write back value+1.
// req/wr/addr/dout are all registered so they stay glitch-free on the bus.
module sys_rmw_engine
  import sys_rmw_engine_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SEED_W = DEF_SEED_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              req,
  output logic              wr,
  input  logic              rdy,
  input  logic [SEED_W-1:0] seed0,
  input  logic [SEED_W-1:0] seed1,
  input  logic [SEED_W-1:0] seed2,
  input  logic [SEED_W-1:0] seed3,
  input  logic [ADDR_W-1:0] range
);

  logic [NUM_LFSR-1:0][SEED_W-1:0] seeds, lfsr_q;
  logic                            step;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  assign seeds = {seed3, seed2, seed1, seed0};

  for (genvar g = 0; g < NUM_LFSR; g++) begin : g_lfsr
    lfsr16 u_lfsr (
      .clk    (clk),
      .rst_n  (rst),
      .en_i   (step),
      .seed_i (seeds[g]),
      .q_o    (lfsr_q[g])
    );
  end

  // req is raised one cycle after entering RD/WR; rdy only counts once req is
  // already high, and the GAP states never look at rdy at all.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    step    = 1'b0;
    case (state_q)
      ST_GEN: begin
        addr_d  = ADDR_W'(lfsr_q) & range;
        step    = 1'b1;
        req_d   = 1'b0;
        state_d = ST_RD;
      end
      ST_RD: begin
        if (!req_q) begin
          req_d = 1'b1;
          wr_d  = 1'b0;
        end else if (rdy) begin
          req_d   = 1'b0;
          dout_d  = din + DATA_W'(1);
          state_d = ST_RD_GAP;
        end
      end
      ST_RD_GAP: state_d = ST_WR;
      ST_WR: begin
        if (!req_q) begin
          req_d = 1'b1;
          wr_d  = 1'b1;
        end else if (rdy) begin
          req_d   = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_WR_GAP;
        end
      end
      ST_WR_GAP: state_d = ST_GEN;
      default: begin
        req_d   = 1'b0;
        wr_d    = 1'b0;
        state_d = ST_GEN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_GEN;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  assign req  = req_q;
  assign wr   = wr_q;
  assign addr = addr_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_sys_rmw_engine.sv
// Self-checking bench: memory model + behavioural LFSR/address model.
module tb_sys_rmw_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] addr, dout;
  logic [63:0] din = '0;
  logic        req, wr;
  logic        rdy = 1'b0;
  logic [15:0] seed0 = '0, seed1 = '0, seed2 = '0, seed3 = '0;
  logic [63:0] range_r = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mem [logic [63:0]];
  logic [15:0] m_lfsr [4];
  logic [63:0] m_range;

  sys_rmw_engine dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .req   (req),
    .wr    (wr),
    .rdy   (rdy),
    .seed0 (seed0),
    .seed1 (seed1),
    .seed2 (seed2),
    .seed3 (seed3),
    .range (range_r)
  );

  always #5 clk = ~clk;

  // Reference LFSR written straight from the polynomial.
  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic model_init(input logic [15:0] s0, s1, s2, s3, input logic [63:0] rng);
    logic [15:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) m_lfsr[i] = (s[i] == 16'h0) ? 16'hACE1 : s[i];
    m_range = rng;
  endtask

  task automatic model_next_addr(output logic [63:0] a);
    a = {m_lfsr[3], m_lfsr[2], m_lfsr[1], m_lfsr[0]} & m_range;
    for (int i = 0; i < 4; i++) m_lfsr[i] = ref_step(m_lfsr[i]);
  endtask

  task automatic apply_reset(input logic [15:0] s0, s1, s2, s3, input logic [63:0] rng);
    @(negedge clk);
    rst = 1'b0; rdy = 1'b0;
    seed0 = s0; seed1 = s1; seed2 = s2; seed3 = s3; range_r = rng;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_init(s0, s1, s2, s3, rng);
  endtask

  // One full read + write-back against the memory model.
  task automatic do_txn(input int rd_dly, input int wr_dly, input bit fd,
                        input logic [63:0] fdin, input bit gap,
                        output logic [63:0] o_addr, output logic [63:0] o_wdata);
    logic [63:0] ea, rv, ev;
    bit stable;
    int n;
    o_addr = 'x; o_wdata = 'x;
    model_next_addr(ea);
    n = 0;
    while (req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (req !== 1'b1) begin
      n_err++; $display("FAIL rd_req_timeout: req=%b required 1", req); return;
    end
    o_addr = addr;
    n_cmp++;
    if (wr !== 1'b0 || addr !== ea) begin
      n_err++; $display("FAIL rd_phase: wr=%b addr=%h required wr=0 addr=%h", wr, addr, ea);
    end
    if (fd) rv = fdin;
    else begin
      if (!mem.exists(ea)) mem[ea] = {$urandom, $urandom};
      rv = mem[ea];
    end
    stable = 1'b1;
    repeat (rd_dly) begin
      @(negedge clk);
      if (req !== 1'b1 || wr !== 1'b0 || addr !== ea) stable = 1'b0;
    end
    if (rd_dly > 0) begin
      n_cmp++;
      if (!stable) begin
        n_err++; $display("FAIL rd_hold: req=%b wr=%b addr=%h required stable 1/0/%h", req, wr, addr, ea);
      end
    end
    din = rv; rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0; din = {$urandom, $urandom};
    n_cmp++;
    if (req !== 1'b0) begin
      n_err++; $display("FAIL rd_done_req: req=%b required 0", req);
    end
    if (gap) begin
      rdy = 1'b1; @(negedge clk); rdy = 1'b0;
    end
    n = 0;
    while (req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (req !== 1'b1) begin
      n_err++; $display("FAIL wr_req_timeout: req=%b required 1", req); return;
    end
    ev = rv + 64'd1;
    o_wdata = dout;
    n_cmp++;
    if (wr !== 1'b1 || addr !== ea || dout !== ev) begin
      n_err++;
      $display("FAIL wr_phase: wr=%b addr=%h dout=%h required wr=1 addr=%h dout=%h", wr, addr, dout, ea, ev);
    end
    stable = 1'b1;
    repeat (wr_dly) begin
      @(negedge clk);
      if (req !== 1'b1 || wr !== 1'b1 || addr !== ea || dout !== ev) stable = 1'b0;
    end
    if (wr_dly > 0) begin
      n_cmp++;
      if (!stable) begin
        n_err++; $display("FAIL wr_hold: req=%b wr=%b addr=%h dout=%h required stable", req, wr, addr, dout);
      end
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    if (!fd) mem[ea] = ev;
    n_cmp++;
    if (req !== 1'b0) begin
      n_err++; $display("FAIL wr_done_req: req=%b required 0", req);
    end
    if (gap) begin
      rdy = 1'b1; @(negedge clk); rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [63:0] a, w;
    @(negedge clk);
    rst = 1'b0; rdy = 1'b0;
    seed0 = 16'h1; seed1 = 16'h2; seed2 = 16'h3; seed3 = 16'h4; range_r = 64'h1FFF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req !== 1'b0 || wr !== 1'b0 || addr !== 64'h0 || dout !== 64'h0) begin
      n_err++; $display("FAIL reset_vals: req=%b wr=%b addr=%h dout=%h required all 0", req, wr, addr, dout);
    end
    rst = 1'b1;
    model_init(16'h1, 16'h2, 16'h3, 16'h4, 64'h1FFF);
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b0) begin
      n_err++; $display("FAIL first_edge_req: req=%b required 0", req);
    end
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b1 || wr !== 1'b0) begin
      n_err++; $display("FAIL second_edge_req: req=%b wr=%b required 1/0", req, wr);
    end
    do_txn(0, 0, 1'b0, '0, 1'b0, a, w);
    n_cmp++;
    if (a !== 64'h1) begin
      n_err++; $display("FAIL first_addr: addr=%h required 0000000000000001", a);
    end
  endtask

  task automatic test_address();
    logic [63:0] a, w;
    bit inrange = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, '0, 1'b0, a, w);
      if (a > 64'h1FFF) inrange = 1'b0;
    end
    n_cmp++;
    if (!inrange) begin
      n_err++; $display("FAIL addr_range: some addr above 1fff, required all <= 1fff");
    end
  endtask

  task automatic test_rmw_value();
    logic [63:0] a, w;
    do_txn(2, 1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, a, w);
    n_cmp++;
    if (w !== 64'h0123_4567_89AB_CDF0) begin
      n_err++; $display("FAIL rmw_value: dout=%h required 0123456789abcdf0", w);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] a, w;
    do_txn(1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, a, w);
    n_cmp++;
    if (w !== 64'h0) begin
      n_err++; $display("FAIL wrap: dout=%h required 0", w);
    end
  endtask

  task automatic test_random_mem();
    logic [63:0] a, w;
    apply_reset(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 64'h1FFF);
    for (int i = 0; i < 100; i++)
      do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, a, w);
  endtask

  task automatic test_range_zero();
    logic [63:0] a, w;
    bit allz = 1'b1;
    apply_reset(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 64'h0);
    for (int i = 0; i < 10; i++) begin
      do_txn(0, 0, 1'b0, '0, 1'b0, a, w);
      if (a !== 64'h0) allz = 1'b0;
    end
    n_cmp++;
    if (!allz) begin
      n_err++; $display("FAIL range_zero: nonzero addr seen, required all 0");
    end
  endtask

  task automatic test_zero_seeds();
    logic [63:0] a, w, prev;
    bit moved = 1'b1;
    apply_reset(16'h0, 16'h0, 16'h0, 16'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    do_txn(0, 0, 1'b0, '0, 1'b0, prev, w);
    n_cmp++;
    if (prev !== 64'hACE1_ACE1_ACE1_ACE1) begin
      n_err++; $display("FAIL zero_seed_first: addr=%h required ace1ace1ace1ace1", prev);
    end
    for (int i = 0; i < 20; i++) begin
      do_txn(0, 0, 1'b0, '0, 1'b0, a, w);
      if (a === prev) moved = 1'b0;
      prev = a;
    end
    n_cmp++;
    if (!moved) begin
      n_err++; $display("FAIL zero_seed_stall: repeated addr seen, required always changing");
    end
  endtask

  task automatic test_handshake();
    logic [63:0] a, w;
    apply_reset(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 64'h1FFF);
    do_txn(50, 50, 1'b0, '0, 1'b1, a, w);
    do_txn(3, 2, 1'b0, '0, 1'b1, a, w);
    do_txn(0, 0, 1'b0, '0, 1'b0, a, w);
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] first, a, w;
    int n;
    apply_reset(16'hBEEF, 16'h0001, 16'hC0DE, 16'h7777, 64'hFFFF);
    do_txn(0, 0, 1'b0, '0, 1'b0, first, w);
    n = 0;
    while (req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    din = 64'h55; rdy = 1'b1; @(negedge clk); rdy = 1'b0;
    n = 0;
    while (!(req === 1'b1 && wr === 1'b1) && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (!(req === 1'b1 && wr === 1'b1)) begin
      n_err++; $display("FAIL midwr_timeout: req=%b wr=%b required 1/1", req, wr);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (req !== 1'b0 || wr !== 1'b0 || addr !== 64'h0 || dout !== 64'h0) begin
      n_err++; $display("FAIL midwr_abort: req=%b wr=%b addr=%h dout=%h required all 0", req, wr, addr, dout);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_init(16'hBEEF, 16'h0001, 16'hC0DE, 16'h7777, 64'hFFFF);
    do_txn(1, 1, 1'b0, '0, 1'b0, a, w);
    n_cmp++;
    if (a !== first) begin
      n_err++; $display("FAIL midwr_restart: addr=%h required %h", a, first);
    end
    do_txn(0, 0, 1'b0, '0, 1'b0, a, w);
  endtask

  initial begin
    test_reset();
    test_address();
    test_rmw_value();
    test_wrap();
    test_random_mem();
    test_range_zero();
    test_zero_seeds();
    test_handshake();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
